// File: rtl/sevenseg_scan.sv
// Four-digit multiplexed seven-segment driver for an MM:SS stopwatch display,
// with per-frame value snapshots and blink-based blanking of the field being adjusted.
module sevenseg_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adj,
  input  logic       sel,
  input  logic       blink_tick,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [5:0]    min_s;
  logic [5:0]    sec_s;
  logic          blink_phase;

  logic [5:0] field;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [3:0] digit;
  logic       dash;
  logic       blank;
  logic [6:0] nxt_seg;
  logic [3:0] nxt_an;
  logic       nxt_dp;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  // Digits 0/1 come from the seconds snapshot, 2/3 from minutes; odd index is the tens digit.
  always_comb begin
    field   = idx[1] ? min_s : sec_s;
    dash    = (field > 6'd59);
    tens    = 4'(field / 6'd10);
    ones    = 4'(field % 6'd10);
    digit   = idx[0] ? tens : ones;
    blank   = adj && blink_phase && (sel ? !idx[1] : idx[1]);
    nxt_seg = 7'b1111111;
    nxt_an  = 4'b1111;
    nxt_dp  = 1'b1;
    if (!blank) begin
      nxt_seg = dash ? 7'b0111111 : enc(digit);
      nxt_an  = ~(4'b0001 << idx);
      nxt_dp  = (idx != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= 2'd0;
      min_s       <= 6'd0;
      sec_s       <= 6'd0;
      blink_phase <= 1'b0;
      seg         <= 7'b1111111;
      an          <= 4'b1111;
      dp          <= 1'b1;
    end else begin
      seg <= nxt_seg;
      an  <= nxt_an;
      dp  <= nxt_dp;
      if (cnt == LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
        // Snapshot only at the frame boundary so a frame never mixes old and new values.
        if (idx == 2'd3) begin
          min_s <= minutes;
          sec_s <= seconds;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (!adj) blink_phase <= 1'b0;
      else if (blink_tick) blink_phase <= ~blink_phase;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: table vectors, directed corner sequences and random
// stimulus, all checked every cycle against a frame-position reference model.
module tb_sevenseg_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] minutes = 6'd0;
  logic [5:0] seconds = 6'd0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic       blink_tick = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int total = 0;
  int bad   = 0;

  // Reference state: position within the scan frame, snapshot values, blink phase
  int pos = 0;
  int min_m = 0;
  int sec_m = 0;
  bit bp_m = 1'b0;
  logic [11:0] exp_q[$];
  logic [6:0] seg_code[10];

  typedef struct {
    logic [5:0] mins;
    logic [5:0] secs;
    logic [6:0] segs[4];
  } vec_t;
  vec_t vecs[6];

  localparam logic [6:0] DASH = 7'b0111111;

  sevenseg_scan #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .minutes(minutes), .seconds(seconds), .adj(adj),
    .sel(sel), .blink_tick(blink_tick), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_out();
    int  idx;
    int  v;
    bit  blank;
    logic [6:0] s;
    if (rst) return {7'b1111111, 4'b1111, 1'b1};
    idx   = pos / DIV;
    v     = (idx < 2) ? sec_m : min_m;
    blank = adj && bp_m && (sel ? (idx < 2) : (idx >= 2));
    if (blank) return {7'b1111111, 4'b1111, 1'b1};
    s = (v > 59) ? DASH : seg_code[(idx % 2 == 0) ? (v % 10) : (v / 10)];
    return {s, ~(4'b0001 << idx), (idx == 2) ? 1'b0 : 1'b1};
  endfunction

  // One clock: predict output from pre-edge state, advance model, compare after the edge.
  task automatic step();
    logic [11:0] e;
    exp_q.push_back(model_out());
    if (rst) begin
      pos = 0; min_m = 0; sec_m = 0; bp_m = 1'b0;
    end else begin
      if (pos == FRAME - 1) begin
        min_m = minutes;
        sec_m = seconds;
      end
      pos  = (pos + 1) % FRAME;
      bp_m = adj ? (bp_m ^ blink_tick) : 1'b0;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("seg", {5'b0, seg}, {5'b0, e[11:5]});
    check("an", {8'b0, an}, {8'b0, e[4:1]});
    check("dp", {11'b0, dp}, {11'b0, e[0]});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_blink();
    blink_tick = 1'b1;
    step();
    blink_tick = 1'b0;
  endtask

  initial begin
    int blanks;
    int guard;
    seg_code = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    vecs[0] = '{6'd12, 6'd34, '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}};
    vecs[1] = '{6'd63, 6'd59, '{7'b0010000, 7'b0010010, DASH, DASH}};
    vecs[2] = '{6'd59, 6'd60, '{DASH, DASH, 7'b0010000, 7'b0010010}};
    vecs[3] = '{6'd0, 6'd0, '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
    vecs[4] = '{6'd7, 6'd5, '{7'b0010010, 7'b1000000, 7'b1111000, 7'b1000000}};
    vecs[5] = '{6'd48, 6'd16, '{7'b0000010, 7'b1111001, 7'b0000000, 7'b0011001}};

    // Reset state
    step();
    check("reset_out", {seg, an, dp}, {7'b1111111, 4'b1111, 1'b1});

    // Table: first frame shows the zero snapshot, the second frame the applied values
    for (int v = 0; v < 6; v++) begin
      do_reset();
      minutes = vecs[v].mins;
      seconds = vecs[v].secs;
      adj = 1'b0;
      for (int c = 1; c <= 2 * FRAME; c++) begin
        step();
        if (c == 1) check("tbl_first_zero", {seg, an, dp}, {7'b1000000, 4'b1110, 1'b1});
        if ((c - 1) >= FRAME && ((c - 1) % DIV) == 0) begin
          int k;
          k = (c - 1 - FRAME) / DIV;
          check("tbl_seg", {5'b0, seg}, {5'b0, vecs[v].segs[k]});
          check("tbl_an", {8'b0, an}, {8'b0, ~(4'b0001 << k)});
          check("tbl_dp", {11'b0, dp}, {11'b0, (k == 2) ? 1'b0 : 1'b1});
        end
      end
    end

    // Seconds change mid-frame must not tear the current frame
    do_reset();
    minutes = 6'd12; seconds = 6'd34;
    repeat (FRAME) step();
    step();
    check("mid_before", {5'b0, seg}, {5'b0, seg_code[4]});
    seconds = 6'd35;
    repeat (FRAME - 1) step();
    step();
    check("mid_after", {5'b0, seg}, {5'b0, seg_code[5]});

    // Blink on seconds field
    do_reset();
    minutes = 6'd12; seconds = 6'd34; adj = 1'b1; sel = 1'b1;
    repeat (FRAME) step();
    pulse_blink();
    blanks = 0;
    for (int c = 0; c < FRAME; c++) begin
      step();
      check("blink_sec_an", {10'b0, an[1:0]}, 12'd3);
      if (an == 4'b1111) blanks++;
    end
    check("blink_sec_cnt", 12'(blanks), 12'(2 * DIV));
    pulse_blink();
    blanks = 0;
    for (int c = 0; c < FRAME; c++) begin
      step();
      if (an == 4'b1111) blanks++;
    end
    check("blink_restore", 12'(blanks), 12'd0);

    // Blink on minutes, then leave adjust mode; tick while adj=0 is ignored
    sel = 1'b0;
    pulse_blink();
    repeat (FRAME) step();
    adj = 1'b0;
    repeat (2) step();
    blink_tick = 1'b1;
    step();
    blink_tick = 1'b0;
    adj = 1'b1;
    blanks = 0;
    for (int c = 0; c < FRAME; c++) begin
      step();
      if (an == 4'b1111) blanks++;
    end
    check("adj0_tick_ignored", 12'(blanks), 12'd0);

    // Reset mid-frame at index 2 with blink active
    do_reset();
    minutes = 6'd12; seconds = 6'd34; adj = 1'b1; sel = 1'b1;
    pulse_blink();
    guard = 0;
    while (pos / DIV != 2 && guard < 4 * FRAME) begin
      step();
      guard++;
    end
    check("rst_reach_idx2", 12'(pos / DIV), 12'd2);
    rst = 1'b1;
    step();
    check("rst_mid_out", {seg, an, dp}, {7'b1111111, 4'b1111, 1'b1});
    rst = 1'b0;
    step();
    check("rst_restart", {seg, an, dp}, {7'b1000000, 4'b1110, 1'b1});
    blanks = 0;
    for (int c = 0; c < FRAME; c++) begin
      step();
      if (an == 4'b1111) blanks++;
    end
    check("rst_blink_clear", 12'(blanks), 12'd0);

    // Random stimulus against the model
    adj = 1'b0; sel = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(19, 0) == 0) minutes = 6'($urandom_range(63, 0));
      if ($urandom_range(19, 0) == 0) seconds = 6'($urandom_range(63, 0));
      if ($urandom_range(49, 0) == 0) adj = ~adj;
      if ($urandom_range(29, 0) == 0) sel = ~sel;
      blink_tick = ($urandom_range(5, 0) == 0);
      rst = ($urandom_range(299, 0) == 0);
      step();
    end
    rst = 1'b0;
    blink_tick = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning the reset, which is synchronous and active-high.
REQ-004 SHALL have port minutes, input, 6, meaning the binary minutes value from the stopwatch counter (0-59 valid).
REQ-005 SHALL have port seconds, input, 6, meaning the binary seconds value from the stopwatch counter (0-59 valid).
REQ-006 SHALL have port adj, input, 1, meaning adjust mode is active.
REQ-007 SHALL have port sel, input, 1, meaning the field under adjustment: 1 = seconds, 0 = minutes.
REQ-008 SHALL have port blink_tick, input, 1, meaning a single-cycle pulse that toggles the blink phase.
REQ-009 SHALL have port seg, output, 7, meaning segment drive {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port an, output, 4, meaning digit anode enables, active-low.
REQ-011 SHALL have port dp, output, 1, meaning the decimal point, active-low.

Function
REQ-012 SHALL keep a refresh counter 0..REFRESH_DIV-1 that increments every cycle, and a 2-bit digit index.
- On count == REFRESH_DIV-1: counter -> 0, index -> index+1 mod 4.
REQ-013 SHALL map digit index to display position as follows:
- 0 = an[0], seconds ones
- 1 = an[1], seconds tens
- 2 = an[2], minutes ones
- 3 = an[3], minutes tens
REQ-014 SHALL load snapshot registers min_s/sec_s from minutes/seconds in the cycle the index wraps 3->0, so the displayed value never tears within one scan frame.
REQ-015 SHALL convert each snapshot field v as follows:
- v in 0..59: tens = v/10, ones = v mod 10.
- v in 60..63: both digits of that field show dash (seg = 0111111).
REQ-016 SHALL encode decimal digits 0-9 active-low {g..a} as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-017 SHALL keep a blink_phase register:
- Toggles on blink_tick when adj=1.
- Forced to 0 in any cycle adj=0; a blink_tick in that cycle is ignored.
REQ-018 SHALL blank a digit (an bit = 1, seg = 1111111, dp = 1) when adj=1 and blink_phase=1 and the digit belongs to the selected field (sel=1: digits 0,1; sel=0: digits 2,3).
- The unselected field is never blanked.
REQ-019 SHALL drive dp = 0 only while digit 2 is active and not blanked, acting as the min/sec separator; dp = 1 otherwise.
REQ-020 SHALL register seg, an and dp:
- Outputs reflect the index, snapshot and blink state of the previous cycle (1-cycle latency).
- Exactly one an bit is low per cycle unless that digit is blanked.
REQ-021 SHALL evaluate adj/sel changes every cycle, so blanking follows them with 1-cycle latency, independent of the snapshot.
REQ-022 SHALL give rst priority over blink_tick and the counter wrap when they coincide.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, set:
- refresh counter = 0, index = 0, min_s = 0, sec_s = 0, blink_phase = 0
- an = 1111, seg = 1111111, dp = 1
REQ-024 SHALL treat rst asserted mid-frame identically to power-up reset.
- The first non-blank output appears on the clock after rst deasserts: an = 1110 showing snapshot 0.

Verification
REQ-025 SHALL be verified with REFRESH_DIV=4: rst, then minutes=12, seconds=34, adj=0.
- First frame shows 0s.
- After the 3->0 wrap, an cycles 1110/1101/1011/0111 every 4 clks with seg 4,3,2,1.
- dp=0 only with an=1011.
REQ-026 SHALL be verified by changing seconds 34->35 mid-frame.
- Displayed seconds stay 34 until the next index wrap 3->0, then show 35.
REQ-027 SHALL be verified with adj=1, sel=1 and one blink_tick.
- an[0] and an[1] stay 1 with seg=1111111; minutes digits remain lit.
- A second blink_tick restores the seconds digits.
REQ-028 SHALL be verified with adj=1, sel=0, blink_phase=1, then adj->0.
- Minutes digits reappear within 2 clks.
- A blink_tick while adj=0 has no effect.
REQ-029 SHALL be verified with minutes=63, seconds=59.
- an[3]/an[2] slots show 0111111; seconds show 5,9.
REQ-030 SHALL be verified by asserting rst for 1 cycle at index 2 with blink active.
- Next cycle: an=1111, seg=1111111, dp=1.
- Afterwards: scan restarts at an=1110 showing 0 and blink_phase=0.
